// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first onto the configuration flip-flop chain.
// One bit per enabled prog_clk cycle; stalls in LOAD on underflow; captures the parity of the displaced chain contents.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 2,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    output logic              old_parity
);
    localparam int WL_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [WL_W-1:0]   word_left_q, word_left_d;
    logic              parity_q, parity_d;
    logic              old_parity_q, old_parity_d;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bits_left_q  <= '0;
            word_left_q  <= '0;
            parity_q     <= 1'b0;
            old_parity_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bits_left_q  <= bits_left_d;
            word_left_q  <= word_left_d;
            parity_q     <= parity_d;
            old_parity_q <= old_parity_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bits_left_d  = bits_left_q;
        word_left_d  = word_left_q;
        parity_d     = parity_q;
        old_parity_d = old_parity_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_LOAD;
                        bits_left_d = CNT_W'(CHAIN_LEN);
                        parity_d    = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bs_valid) begin
                        state_d = ST_SHIFT;
                        shift_d = bs_data;
                        if (int'(bits_left_q) < WORD_W) begin
                            word_left_d = WL_W'(bits_left_q);
                        end else begin
                            word_left_d = WL_W'(WORD_W);
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_d     = shift_q >> 1;
                    word_left_d = word_left_q - WL_W'(1);
                    bits_left_d = bits_left_q - CNT_W'(1);
                    parity_d    = parity_q ^ ccff_tail;
                    // Last bit of the word: keep it on ccff_head so the head holds while the chain is frozen.
                    if (word_left_q == WL_W'(1)) begin
                        shift_d = shift_q;
                        if (bits_left_q == CNT_W'(1)) begin
                            state_d      = ST_DONE;
                            old_parity_d = parity_q ^ ccff_tail;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bs_ready     = (state_q == ST_LOAD);
        chain_clk_en = (state_q == ST_SHIFT);
        busy         = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
        done         = (state_q == ST_DONE);
        ccff_head    = shift_q[0];
        old_parity   = old_parity_q;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Configuration-chain controller that serialises bitstream words onto the fabric's configuration flip-flop chain (ccff_head → … → ccff_tail) through connection and switch blocks.
- Drives one bit per enabled prog_clk cycle, with a clock-enable for the chain's integrated clock gate.
- Tracks the bit count, stalls on bitstream underflow and supports abort.
- Captures the parity of the previous chain contents as they leave ccff_tail, for readback checking.

Parameters:
- CHAIN_LEN, 2, total configuration bits in the chain (≥1).
- WORD_W, 8, bitstream word width (≥1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  configuration clock; all state updates on the rising edge.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- abort  input  1  stop the load; return to IDLE next cycle.
- bs_data  input  WORD_W  bitstream word; bit 0 is shifted first.
- bs_valid  input  1  bs_data is valid.
- bs_ready  output  1  loader accepts a word this cycle.
- ccff_tail  input  1  serial output of the last chain flop.
- ccff_head  output  1  serial data into the first chain flop.
- chain_clk_en  output  1  enable for the chain's clock gate; the chain shifts on each prog_clk edge ending a cycle where this is 1.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  high in DONE; stays high until start or reset.
- old_parity  output  1  XOR of all CHAIN_LEN bits that left ccff_tail during the last completed load.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE.
- Reset (prog_reset=1 at an edge): state=IDLE; bs_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, old_parity=0; counters and shift register cleared. Reset overrides abort and start.
- IDLE/DONE + start=1: go to LOAD next cycle; clear bits_left to CHAIN_LEN, the parity accumulator and done.
- LOAD:
  - bs_ready=1 and chain_clk_en=0.
  - On bs_valid & bs_ready, latch bs_data into the shift register; set word_left = min(WORD_W, bits_left); go to SHIFT.
  - bs_valid=0: stay in LOAD (stall) with the chain frozen.
- SHIFT:
  - bs_ready=0 and chain_clk_en=1 every cycle; ccff_head = shift_reg[0], registered so there is no combinational path from bs_data.
  - Each cycle: shift_reg shifts right, word_left and bits_left decrement, and parity_acc ^= ccff_tail sampled that cycle.
  - When word_left reaches 0 after the current bit:
    - bits_left > 0: go to LOAD.
    - otherwise: go to DONE and set old_parity = final parity_acc.
- Last word: only bits_left bits are shifted; upper bits are discarded.
- Latency:
  - First ccff_head bit appears on the cycle after the accepting handshake.
  - A load with no stalls takes ceil(CHAIN_LEN/WORD_W) LOAD cycles plus CHAIN_LEN SHIFT cycles.
  - Exactly CHAIN_LEN chain_clk_en cycles per load.
- abort (any state except under reset):
  - chain_clk_en=0 and bs_ready=0 from the next cycle; state=IDLE.
  - done stays 0 and old_parity is unchanged; the chain is left partially shifted.
  - An abort in the same cycle as a LOAD handshake discards the word.
- start while busy is ignored. start and abort in the same cycle: abort wins.
- ccff_head holds its last value when chain_clk_en=0.
- No output depends combinationally on bs_valid except through registered state.

Test Plan:
- CHAIN_LEN=2, WORD_W=8; start, then bs_data=8'h02 → one LOAD handshake; ccff_head=0 then 1 over 2 cycles with chain_clk_en=1; chain model holds {first=1, last=0}; done=1 on the next cycle.
- CHAIN_LEN=20, WORD_W=8; words 0xA5, 0x3C, 0xFF with no stalls → 3 handshakes; 8+8+4 enabled cycles (20 total); bit sequence matches LSB-first; 0xFF upper nibble never appears; busy deasserts as done asserts.
- Same config with bs_valid held low for 5 cycles after word 1 → chain_clk_en=0 and ccff_head steady for those 5 cycles; final chain contents are identical to the no-stall case.
- Chain model preloaded with 20 bits of odd parity, then a full load → old_parity=1; a second load of the same bitstream yields old_parity equal to the parity of that bitstream.
- abort asserted on the 3rd SHIFT cycle of word 2 → next cycle chain_clk_en=0, state IDLE, done=0, old_parity unchanged; a new start reloads all 20 bits correctly.
- prog_reset asserted mid-SHIFT together with start and abort → next cycle all outputs are at their reset values; start pulsed during busy is ignored (no extra handshake or counter reset).
